receiver_ddc_cic4: RTL

// - Receive-side counterpart of the transmit chain. Mixes the 30.72 MHz real IF samples with the mydds carrier (cosine) down to baseband.
// - Decimates by 4 through a 4-stage CIC to 7.68 MHz for the downstream receive FIR/RCF.
// - Single clock domain, clk_30p72MHz. Output is a sample stream qualified by a one-cycle strobe.

---
 rtl/rx_ddc_pkg.sv | 36 +++
 rtl/cic_decim_core.sv | 94 +++++++++
 rtl/receiver_ddc_cic4.sv | 51 +++++
 3 files changed

// File: rtl/rx_ddc_pkg.sv
// Shared widths and the mixer's saturating shift for the receive DDC.
package rx_ddc_pkg;

  localparam int unsigned IN_W   = 16;
  localparam int unsigned COS_W  = 10;
  localparam int unsigned R      = 4;
  localparam int unsigned N      = 4;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned LOG2_R = $clog2(R);
  localparam int unsigned ACC_W  = IN_W + N * LOG2_R;
  localparam int unsigned PROD_W = IN_W + COS_W;

  // Mixer result: IN_W-bit sample plus a flag set when it was clipped.
  typedef struct packed {
    logic [IN_W-1:0] data;
    logic            sat;
  } mix_t;

  // Scale a full product back to IN_W bits (floor) and clip on overflow.
  function automatic mix_t sat_shift(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] shifted;
    mix_t                     res;
    shifted  = prod >>> (COS_W - 1);
    res.sat  = 1'b0;
    res.data = shifted[IN_W-1:0];
    if (!shifted[PROD_W-1] && (|shifted[PROD_W-2:IN_W-1])) begin
      res.data = {1'b0, {(IN_W-1){1'b1}}};
      res.sat  = 1'b1;
    end else if (shifted[PROD_W-1] && !(&shifted[PROD_W-2:IN_W-1])) begin
      res.data = {1'b1, {(IN_W-1){1'b0}}};
      res.sat  = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_decim_core.sv
// N-stage CIC decimator by R: valid-gated integrators, phase counter,
// tick-gated comb chain and registered output.
module cic_decim_core
  import rx_ddc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [IN_W-1:0]  in_data_i,
  output logic [OUT_W-1:0] y_o,
  output logic             y_valid_o
);

  logic [N:1]        v_q;
  logic [ACC_W-1:0]  int_q      [1:N];
  logic [ACC_W-1:0]  dly_q      [1:N];
  logic [ACC_W-1:0]  comb_in_c  [1:N];
  logic [OUT_W-1:0]  comb_out_c;
  logic [LOG2_R-1:0] phase_q, phase_d;
  logic              tick_c;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              y_valid_q, y_valid_d;

  // Comb chain from the last integrator; output keeps the top OUT_W bits (divide by R^N).
  always_comb begin : comb_chain
    logic [ACC_W-1:0] acc;
    acc = int_q[N];
    for (int unsigned k = 1; k <= N; k++) begin
      comb_in_c[k] = acc;
      acc          = acc - dly_q[k];
    end
    comb_out_c = acc[ACC_W-1 -: OUT_W];
  end

  // Decimation phase and output next-state.
  always_comb begin
    phase_d   = phase_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    tick_c    = v_q[N] && (phase_q == LOG2_R'(R - 1));
    if (v_q[N]) begin
      phase_d = phase_q + LOG2_R'(1);
    end
    if (tick_c) begin
      y_d       = comb_out_c;
      y_valid_d = 1'b1;
    end
  end

  // Valid pipeline and integrators; each stage advances only with its own valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int unsigned k = 1; k <= N; k++) begin
        int_q[k] <= '0;
      end
    end else begin
      v_q <= {v_q[N-1:1], in_valid_i};
      if (in_valid_i) begin
        int_q[1] <= int_q[1] + ACC_W'($signed(in_data_i));
      end
      for (int unsigned k = 2; k <= N; k++) begin
        if (v_q[k-1]) begin
          int_q[k] <= int_q[k] + int_q[k-1];
        end
      end
    end
  end

  // Comb delays, phase counter and output registers, updated on the decimation tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 1; k <= N; k++) begin
        dly_q[k] <= '0;
      end
      phase_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      if (tick_c) begin
        for (int unsigned k = 1; k <= N; k++) begin
          dly_q[k] <= comb_in_c[k];
        end
      end
      phase_q   <= phase_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;

endmodule

// File: rtl/receiver_ddc_cic4.sv
// Receive DDC: mix real IF with the carrier cosine to baseband, then
// decimate by R through an N-stage CIC.
module receiver_ddc_cic4
  import rx_ddc_pkg::*;
(
  input  logic             clk_30p72MHz,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [IN_W-1:0]  x_in,
  input  logic [COS_W-1:0] cosine,
  output logic [OUT_W-1:0] y_out,
  output logic             y_valid,
  output logic             mix_sat
);

  logic signed [PROD_W-1:0] prod_c;
  mix_t                     mix_c;
  logic [IN_W-1:0]          mix_q, mix_d;
  logic                     mix_valid_q;
  logic                     mix_sat_q;

  // Full-precision product, then scale and clip back to IN_W bits.
  assign prod_c = PROD_W'($signed(x_in)) * PROD_W'($signed(cosine));
  assign mix_c  = sat_shift(prod_c);
  assign mix_d  = x_valid ? mix_c.data : mix_q;

  // Mixer register and stage-0 valid; the clip flag pulses with its sample.
  always_ff @(posedge clk_30p72MHz) begin
    if (!reset) begin
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      mix_sat_q   <= 1'b0;
    end else begin
      mix_q       <= mix_d;
      mix_valid_q <= x_valid;
      mix_sat_q   <= x_valid & mix_c.sat;
    end
  end

  cic_decim_core u_cic (
    .clk_i      (clk_30p72MHz),
    .rst_ni     (reset),
    .in_valid_i (mix_valid_q),
    .in_data_i  (mix_q),
    .y_o        (y_out),
    .y_valid_o  (y_valid)
  );

  assign mix_sat = mix_sat_q;

endmodule
